beep_mixer: RTL and testbench

BEEP_MIXER -- requirements
Module: beep_mixer

---
 rtl/beep_mixer.sv | 142 ++++++++++++++
 tb/tb_beep_mixer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/beep_mixer.sv
// rtl/beep_mixer.sv - buzzer mixer: music pass-through with prioritized, gap-guarded sound effects
// and a duty-cycle volume gate.
module beep_mixer #(
  parameter int SFX_LEN = 6000000,
  parameter int GAP_LEN = 60000,
  parameter int P_JUMP  = 68181,
  parameter int P_HIT   = 136363,
  parameter int P_OVER  = 272727
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       music_beep,
  input  logic [2:0] sfx_trig,
  input  logic [1:0] volume,
  output logic       beep_out,
  output logic       sfx_busy
);

  typedef enum logic [1:0] {IDLE, GAP_IN, SFX, GAP_OUT} state_t;

  localparam logic [1:0]  EV_NONE  = 2'd0;
  localparam logic [1:0]  EV_JUMP  = 2'd1;
  localparam logic [1:0]  EV_HIT   = 2'd2;
  localparam logic [1:0]  EV_OVER  = 2'd3;
  localparam logic [16:0] GAP_LAST = 17'(GAP_LEN - 1);
  localparam logic [22:0] LEN_LAST = 23'(SFX_LEN - 1);

  state_t      state_q;
  logic [1:0]  ev_q;
  logic [16:0] gap_q;
  logic [22:0] len_q;
  logic [18:0] tone_q;
  logic [2:0]  gate_q;
  logic        beep_q;
  logic        busy_q;

  logic [1:0]  trig_pri;
  logic [18:0] period;
  logic        tone_bit;
  logic        gate;
  logic        source;
  logic        beep_d;

  // Event code doubles as priority, so one >= compare decides restart vs ignore.
  always_comb begin
    trig_pri = EV_NONE;
    if (sfx_trig[2])      trig_pri = EV_OVER;
    else if (sfx_trig[1]) trig_pri = EV_HIT;
    else if (sfx_trig[0]) trig_pri = EV_JUMP;
  end

  always_comb begin
    period = 19'(P_JUMP);
    case (ev_q)
      EV_HIT:  period = 19'(P_HIT);
      EV_OVER: period = 19'(P_OVER);
      default: period = 19'(P_JUMP);
    endcase
  end

  assign tone_bit = tone_q > (period >> 1);

  always_comb begin
    gate = 1'b0;
    case (volume)
      2'd3:    gate = 1'b1;
      2'd2:    gate = (gate_q < 3'd4);
      2'd1:    gate = (gate_q < 3'd2);
      default: gate = 1'b0;
    endcase
  end

  always_comb begin
    source = 1'b0;
    case (state_q)
      IDLE:    source = music_beep;
      SFX:     source = tone_bit;
      default: source = 1'b0;
    endcase
  end

  assign beep_d = gate & source;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ev_q    <= EV_NONE;
      gap_q   <= '0;
      len_q   <= '0;
      tone_q  <= '0;
      gate_q  <= '0;
      beep_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      gate_q <= gate_q + 3'd1;
      beep_q <= beep_d;
      // ev_q is NONE in IDLE, so any trigger starts an effect from there.
      if (trig_pri != EV_NONE && trig_pri >= ev_q) begin
        ev_q    <= trig_pri;
        gap_q   <= '0;
        state_q <= GAP_IN;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: ;
          GAP_IN: begin
            if (gap_q == GAP_LAST) begin
              state_q <= SFX;
              tone_q  <= '0;
              len_q   <= '0;
            end else begin
              gap_q <= gap_q + 17'd1;
            end
          end
          SFX: begin
            tone_q <= (tone_q == period - 19'd1) ? '0 : tone_q + 19'd1;
            if (len_q == LEN_LAST) begin
              state_q <= GAP_OUT;
              gap_q   <= '0;
            end else begin
              len_q <= len_q + 23'd1;
            end
          end
          GAP_OUT: begin
            if (gap_q == GAP_LAST) begin
              state_q <= IDLE;
              ev_q    <= EV_NONE;
              busy_q  <= 1'b0;
            end else begin
              gap_q <= gap_q + 17'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign beep_out = beep_q;
  assign sfx_busy = busy_q;

endmodule

// File: tb/tb_beep_mixer.sv
// tb/tb_beep_mixer.sv - self-checking bench for beep_mixer: per-cycle reference model
// plus directed scenarios with hand-computed totals.
module tb_beep_mixer;

  localparam int S   = 100;
  localparam int G   = 4;
  localparam int PJ  = 10;
  localparam int PH  = 20;
  localparam int PO  = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       music_beep = 1'b0;
  logic [2:0] sfx_trig = 3'b000;
  logic [1:0] volume = 2'd3;
  logic       beep_out;
  logic       sfx_busy;

  int n_checks = 0;
  int n_pass   = 0;

  beep_mixer #(
    .SFX_LEN(S), .GAP_LEN(G), .P_JUMP(PJ), .P_HIT(PH), .P_OVER(PO)
  ) dut (
    .clk(clk), .rst(rst), .music_beep(music_beep), .sfx_trig(sfx_trig),
    .volume(volume), .beep_out(beep_out), .sfx_busy(sfx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int period_of(input int ev);
    case (ev)
      3:       return PO;
      2:       return PH;
      default: return PJ;
    endcase
  endfunction

  // Reference model: an effect is described only by its event and its age in cycles.
  int m_active = 0;
  int m_ev     = 0;
  int m_age    = 0;
  int m_gate   = 0;
  int exp_beep = 0;
  int exp_busy = 0;

  always @(posedge clk) begin
    int src, g, a, pri;
    if (rst) begin
      m_active = 0; m_ev = 0; m_age = 0; m_gate = 0;
      exp_beep = 0; exp_busy = 0;
    end else begin
      src = 0;
      if (!m_active) src = int'(music_beep);
      else begin
        a = m_age - 1;
        if (a >= G && a < G + S)
          src = (((a - G) % period_of(m_ev)) > period_of(m_ev) / 2) ? 1 : 0;
      end
      case (volume)
        2'd3:    g = 1;
        2'd2:    g = (m_gate < 4) ? 1 : 0;
        2'd1:    g = (m_gate < 2) ? 1 : 0;
        default: g = 0;
      endcase
      exp_beep = g & src;
      pri = sfx_trig[2] ? 3 : sfx_trig[1] ? 2 : sfx_trig[0] ? 1 : 0;
      if (pri != 0 && (!m_active || pri >= m_ev)) begin
        m_active = 1; m_ev = pri; m_age = 1;
      end else if (m_active) begin
        m_age++;
        if (m_age > 2 * G + S) begin m_active = 0; m_ev = 0; end
      end
      exp_busy = m_active;
      m_gate = (m_gate + 1) % 8;
    end
    #3;
    check("model_beep_out", int'(beep_out), exp_beep);
    check("model_sfx_busy", int'(sfx_busy), exp_busy);
  end

  task automatic run(input int n, output int ones, output int busy);
    ones = 0; busy = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ones += int'(beep_out);
      busy += int'(sfx_busy);
      sfx_trig = 3'b000;
    end
  endtask

  initial begin
    int o1, b1, o2, b2;
    logic prev;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_beep_out", int'(beep_out), 0);
    check("reset_sfx_busy", int'(sfx_busy), 0);
    run(4, o1, b1);

    // Music pass-through at full volume, one-cycle latency.
    for (int i = 0; i < 40; i++) begin
      prev = music_beep;
      @(negedge clk);
      check("passthru_beep", int'(beep_out), int'(prev));
      check("passthru_busy", int'(sfx_busy), 0);
      music_beep = ~music_beep;
    end
    music_beep = 1'b0;
    run(4, o1, b1);

    // Jump effect alone.
    sfx_trig = 3'b001;
    run(120, o1, b1);
    check("jump_busy_cycles", b1, 108);
    check("jump_tone_highs", o1, 40);

    // Hit wins over jump in the same cycle; a later jump is ignored.
    sfx_trig = 3'b011;
    run(30, o1, b1);
    sfx_trig = 3'b001;
    run(100, o2, b2);
    check("hit_busy_cycles", b1 + b2, 108);
    check("hit_tone_highs", o1 + o2, 45);

    // Game-over during a jump restarts the gap and plays the low tone.
    sfx_trig = 3'b001;
    run(30, o1, b1);
    sfx_trig = 3'b100;
    run(130, o2, b2);
    check("over_busy_cycles", b1 + b2, 138);
    check("over_tone_highs", o1 + o2, 46);

    // Volume duty cycles with music held high.
    music_beep = 1'b1;
    volume = 2'd1; run(16, o1, b1); check("vol1_highs", o1, 4);
    volume = 2'd2; run(16, o1, b1); check("vol2_highs", o1, 8);
    volume = 2'd0; run(16, o1, b1); check("vol0_highs", o1, 0);
    volume = 2'd3; run(16, o1, b1); check("vol3_highs", o1, 16);

    // Reset in the middle of an effect.
    music_beep = 1'b0;
    sfx_trig = 3'b001;
    run(54, o1, b1);
    rst = 1'b1;
    #1;
    check("midsfx_rst_beep", int'(beep_out), 0);
    check("midsfx_rst_busy", int'(sfx_busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    music_beep = 1'b1;
    run(20, o1, b1);
    check("after_rst_busy", b1, 0);
    check("after_rst_music", o1, 20);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = 1'b0;
      music_beep = 1'($urandom_range(0, 1));
      sfx_trig = ($urandom_range(0, 99) < 2) ? 3'($urandom_range(1, 7)) : 3'b000;
      if ($urandom_range(0, 49) == 0) volume = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 799) == 0) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    sfx_trig = 3'b000;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
